// File: rtl/kbd_pkg.sv
// Shared constants, FSM state type and ASCII-to-HID encoder for kbd_report_encoder.
// Build option KBD_ENC_CTRL_EN maps control codes 1-26 onto ctrl+letter keystrokes.
package kbd_pkg;

   localparam logic [7:0] SHIFT_MASK = 8'h22;
   localparam logic [7:0] CTRL_MASK  = 8'h11;
   localparam logic [7:0] MOD_NONE   = 8'h00;
   localparam logic [7:0] MOD_LSHIFT = SHIFT_MASK & 8'h0F;
   localparam logic [7:0] MOD_LCTRL  = CTRL_MASK & 8'h0F;

   localparam logic [7:0] REG_DATA    = 8'h00;
   localparam logic [7:0] REG_TICKS   = 8'h01;
   localparam logic [7:0] REG_CLEAR   = 8'h02;
   localparam logic [7:0] TICKS_RESET = 8'd8;

   localparam logic [7:0] SC_NONE     = 8'd0;
   localparam logic [7:0] SC_A        = 8'd4;
   localparam logic [7:0] SC_1        = 8'd30;
   localparam logic [7:0] SC_0        = 8'd39;
   localparam logic [7:0] SC_ENTER    = 8'd40;
   localparam logic [7:0] SC_ESC      = 8'd41;
   localparam logic [7:0] SC_BKSP     = 8'd42;
   localparam logic [7:0] SC_TAB      = 8'd43;
   localparam logic [7:0] SC_SPACE    = 8'd44;
   localparam logic [7:0] SC_MINUS    = 8'd45;
   localparam logic [7:0] SC_EQUAL    = 8'd46;
   localparam logic [7:0] SC_LBRACKET = 8'd47;
   localparam logic [7:0] SC_RBRACKET = 8'd48;
   localparam logic [7:0] SC_BSLASH   = 8'd49;
   localparam logic [7:0] SC_SEMI     = 8'd51;
   localparam logic [7:0] SC_QUOTE    = 8'd52;
   localparam logic [7:0] SC_GRAVE    = 8'd53;
   localparam logic [7:0] SC_COMMA    = 8'd54;
   localparam logic [7:0] SC_DOT      = 8'd55;
   localparam logic [7:0] SC_SLASH    = 8'd56;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_PRESS,
      ST_HOLD,
      ST_RELEASE,
      ST_GAP
   } kbd_state_t;

   // Returns {valid, modifiers, scancode}; an invalid result carries zero fields.
   function automatic logic [16:0] char2scancode(input logic [7:0] c);
      logic       valid;
      logic       shifted;
      logic [7:0] mods;
      logic [7:0] code;
      valid   = 1'b1;
      shifted = 1'b0;
      mods    = MOD_NONE;
      code    = SC_NONE;
      if (c >= 8'h61 && c <= 8'h7A) begin
         code = c - 8'h61 + SC_A;
      end else if (c >= 8'h41 && c <= 8'h5A) begin
         code    = c - 8'h41 + SC_A;
         shifted = 1'b1;
      end else if (c >= 8'h31 && c <= 8'h39) begin
         code = c - 8'h31 + SC_1;
      end else begin
         case (c)
            8'h30: code = SC_0;
            8'h0D: code = SC_ENTER;
            8'h1B: code = SC_ESC;
            8'h08: code = SC_BKSP;
            8'h09: code = SC_TAB;
            8'h20: code = SC_SPACE;
            8'h2D: code = SC_MINUS;
            8'h3D: code = SC_EQUAL;
            8'h5B: code = SC_LBRACKET;
            8'h5D: code = SC_RBRACKET;
            8'h5C: code = SC_BSLASH;
            8'h3B: code = SC_SEMI;
            8'h27: code = SC_QUOTE;
            8'h60: code = SC_GRAVE;
            8'h2C: code = SC_COMMA;
            8'h2E: code = SC_DOT;
            8'h2F: code = SC_SLASH;
            8'h21: begin code = SC_1;          shifted = 1'b1; end
            8'h40: begin code = SC_1 + 8'd1;   shifted = 1'b1; end
            8'h23: begin code = SC_1 + 8'd2;   shifted = 1'b1; end
            8'h24: begin code = SC_1 + 8'd3;   shifted = 1'b1; end
            8'h25: begin code = SC_1 + 8'd4;   shifted = 1'b1; end
            8'h5E: begin code = SC_1 + 8'd5;   shifted = 1'b1; end
            8'h26: begin code = SC_1 + 8'd6;   shifted = 1'b1; end
            8'h2A: begin code = SC_1 + 8'd7;   shifted = 1'b1; end
            8'h28: begin code = SC_1 + 8'd8;   shifted = 1'b1; end
            8'h29: begin code = SC_0;          shifted = 1'b1; end
            8'h5F: begin code = SC_MINUS;      shifted = 1'b1; end
            8'h2B: begin code = SC_EQUAL;      shifted = 1'b1; end
            8'h7B: begin code = SC_LBRACKET;   shifted = 1'b1; end
            8'h7D: begin code = SC_RBRACKET;   shifted = 1'b1; end
            8'h7C: begin code = SC_BSLASH;     shifted = 1'b1; end
            8'h3A: begin code = SC_SEMI;       shifted = 1'b1; end
            8'h22: begin code = SC_QUOTE;      shifted = 1'b1; end
            8'h7E: begin code = SC_GRAVE;      shifted = 1'b1; end
            8'h3C: begin code = SC_COMMA;      shifted = 1'b1; end
            8'h3E: begin code = SC_DOT;        shifted = 1'b1; end
            8'h3F: begin code = SC_SLASH;      shifted = 1'b1; end
            default: begin
`ifdef KBD_ENC_CTRL_EN
               if (c >= 8'h01 && c <= 8'h1A) begin
                  code = c + 8'd3;
                  mods = MOD_LCTRL;
               end else begin
                  valid = 1'b0;
               end
`else
               valid = 1'b0;
`endif
            end
         endcase
      end
      if (shifted) mods = MOD_LSHIFT;
      return {valid, mods, code};
   endfunction

endpackage

// File: rtl/kbd_char_fifo.sv
// Synchronous character FIFO with registered read data; DEPTH must be a power of two (>= 2).
module kbd_char_fifo
   import kbd_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   input  logic       rd_en,
   output logic [7:0] rd_data,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_MASK = AW'(DEPTH - 1);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_wr;
   logic          do_rd;

   assign full  = (count == (AW + 1)'(DEPTH));
   assign empty = (count == '0);
   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && !empty;

   always_ff @(posedge clk_i) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         rd_data <= 8'h00;
      end else begin
         if (do_wr) wr_ptr <= (wr_ptr + AW'(1)) & PTR_MASK;
         if (do_rd) begin
            rd_ptr  <= (rd_ptr + AW'(1)) & PTR_MASK;
            rd_data <= mem[rd_ptr];
         end
         case ({do_wr, do_rd})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/kbd_report_encoder.sv
// Turns CPU-written ASCII into boot-keyboard press/release report pairs.
// Define KBD_ENC_CTRL_EN to encode control codes 1-26 as left-ctrl + letter.
module kbd_report_encoder
   import kbd_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int TICK_DIV   = 48000
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       R_W_n,
   input  logic [7:0] reg_addr_i,
   input  logic [7:0] data_i,
   input  logic       usb_cs,
   output logic [7:0] data_o,
   output logic [1:0] typ,
   output logic       report,
   output logic [7:0] key_modifiers,
   output logic [7:0] key1,
   output logic [7:0] key2
);

   localparam int PW = $clog2(TICK_DIV + 1);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   kbd_state_t state, next_state;

   logic       wr_access;
   logic       push_req;
   logic       fifo_pop;
   logic       fifo_full;
   logic       fifo_empty;
   logic [7:0] fifo_data;
   logic       enc_valid;
   logic [7:0] enc_mods;
   logic [7:0] enc_code;
   logic [7:0] tick_count;
   logic       overflow;
   logic       unmapped;
   logic       set_unmapped;
   logic       busy;
   logic [PW-1:0] prescale;
   logic [7:0]    ticks_left;
   logic          wait_done;

   assign wr_access = usb_cs && !R_W_n;
   assign push_req  = wr_access && (reg_addr_i == REG_DATA);
   assign key2      = 8'h00;
   assign busy      = (state != ST_IDLE) || !fifo_empty;
   assign wait_done = (prescale == PRE_LAST) && (ticks_left == 8'd1);
   assign {enc_valid, enc_mods, enc_code} = char2scancode(fifo_data);

   kbd_char_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .wr_en   (push_req),
      .wr_data (data_i),
      .rd_en   (fifo_pop),
      .rd_data (fifo_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         tick_count <= TICKS_RESET;
         overflow   <= 1'b0;
         unmapped   <= 1'b0;
      end else begin
         if (wr_access && reg_addr_i == REG_TICKS) tick_count <= data_i;
         if (wr_access && reg_addr_i == REG_CLEAR) begin
            overflow <= 1'b0;
            unmapped <= 1'b0;
         end
         if (push_req && fifo_full) overflow <= 1'b1;
         if (set_unmapped) unmapped <= 1'b1;
      end
   end

   always_comb begin
      data_o = 8'h00;
      case (reg_addr_i)
         REG_DATA:  data_o = {3'b000, unmapped, overflow, fifo_full, fifo_empty, busy};
         REG_TICKS: data_o = tick_count;
         default:   data_o = 8'h00;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state <= ST_IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state   = state;
      fifo_pop     = 1'b0;
      set_unmapped = 1'b0;
      report       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               next_state = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (enc_valid) begin
               next_state = ST_PRESS;
            end else begin
               set_unmapped = 1'b1;
               next_state   = ST_IDLE;
            end
         end
         ST_PRESS: begin
            report     = 1'b1;
            next_state = ST_HOLD;
         end
         ST_HOLD: begin
            if (wait_done) next_state = ST_RELEASE;
         end
         ST_RELEASE: begin
            report     = 1'b1;
            next_state = ST_GAP;
         end
         ST_GAP: begin
            if (wait_done) next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // The tick count is sampled on HOLD/GAP entry so register writes never stretch a wait in progress.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         prescale   <= '0;
         ticks_left <= 8'd1;
      end else if (state == ST_PRESS || state == ST_RELEASE) begin
         prescale   <= '0;
         ticks_left <= (tick_count == 8'd0) ? 8'd1 : tick_count;
      end else if (state == ST_HOLD || state == ST_GAP) begin
         if (prescale == PRE_LAST) begin
            prescale   <= '0;
            ticks_left <= ticks_left - 8'd1;
         end else begin
            prescale <= prescale + PW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         key1          <= 8'h00;
         key_modifiers <= 8'h00;
         typ           <= 2'd0;
      end else begin
         typ <= 2'd1;
         if (state == ST_LOAD && enc_valid) begin
            key1          <= enc_code;
            key_modifiers <= enc_mods;
         end else if (state == ST_HOLD && wait_done) begin
            key1          <= 8'h00;
            key_modifiers <= 8'h00;
         end
      end
   end

endmodule

// File: tb/tb_kbd_report_encoder.sv
// Self-checking bench for kbd_report_encoder; expectations follow KBD_ENC_CTRL_EN when defined.
module tb_kbd_report_encoder;

   localparam int TICK_DIV = 4;

   logic       clk_i = 1'b0;
   logic       rst_n_i = 1'b0;
   logic       R_W_n = 1'b1;
   logic [7:0] reg_addr_i = 8'h00;
   logic [7:0] data_i = 8'h00;
   logic       usb_cs = 1'b0;
   logic [7:0] data_o;
   logic [1:0] typ;
   logic       report;
   logic [7:0] key_modifiers;
   logic [7:0] key1;
   logic [7:0] key2;

   typedef struct {
      logic [7:0] ch;
      logic       valid;
      logic [7:0] key;
      logic [7:0] mods;
   } vec_t;

   typedef struct {
      logic [7:0] key;
      logic [7:0] mods;
   } rpt_t;

   vec_t vecs[$];
   rpt_t exp_q[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   cycle = 0;
   int   n_reports = 0;
   int   press_cycle = 0;
   int   rel_cycle = 0;
   int   last_wr_cycle = 0;

   kbd_report_encoder #(
      .FIFO_DEPTH (16),
      .TICK_DIV   (TICK_DIV)
   ) dut (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .R_W_n         (R_W_n),
      .reg_addr_i    (reg_addr_i),
      .data_i        (data_i),
      .usb_cs        (usb_cs),
      .data_o        (data_o),
      .typ           (typ),
      .report        (report),
      .key_modifiers (key_modifiers),
      .key1          (key1),
      .key2          (key2)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cycle++;

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Scoreboard consumer: every report pulse must match the oldest expected record.
   always @(negedge clk_i) begin
      if (rst_n_i && report) begin
         rpt_t e;
         n_reports++;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL spurious_report: got key1=0x%0h mod=0x%0h, required no report", key1, key_modifiers);
         end else begin
            e = exp_q.pop_front();
            check("report_key1", key1, e.key);
            check("report_mods", key_modifiers, e.mods);
            check("report_key2", key2, 0);
            if (e.key != 8'h00) press_cycle = cycle;
            else                rel_cycle = cycle;
         end
      end
   end

   task automatic push_expected(input logic valid, input logic [7:0] key, input logic [7:0] mods);
      rpt_t r;
      if (valid) begin
         r.key = key;   r.mods = mods;   exp_q.push_back(r);
         r.key = 8'h00; r.mods = 8'h00;  exp_q.push_back(r);
      end
   endtask

   task automatic add_vec(input logic [7:0] ch, input logic valid, input logic [7:0] key, input logic [7:0] mods);
      vec_t v;
      v.ch = ch; v.valid = valid; v.key = key; v.mods = mods;
      vecs.push_back(v);
   endtask

   task automatic cpu_write(input logic [7:0] addr, input logic [7:0] d);
      reg_addr_i = addr;
      data_i     = d;
      R_W_n      = 1'b0;
      usb_cs     = 1'b1;
      @(negedge clk_i);
      usb_cs        = 1'b0;
      R_W_n         = 1'b1;
      reg_addr_i    = 8'h00;
      last_wr_cycle = cycle;
   endtask

   task automatic cpu_read(input logic [7:0] addr, output logic [7:0] d);
      reg_addr_i = addr;
      R_W_n      = 1'b1;
      usb_cs     = 1'b1;
      #1 d = data_o;
      @(negedge clk_i);
      usb_cs     = 1'b0;
      reg_addr_i = 8'h00;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      reg_addr_i = 8'h00;
      #1;
      while (data_o[0] && n < budget) begin
         @(negedge clk_i);
         #1;
         n++;
      end
      check("idle_within_budget", data_o[0], 0);
   endtask

   task automatic wait_reports(input int target, input int budget);
      int n;
      n = 0;
      while (n_reports < target && n < budget) begin
         @(negedge clk_i);
         n++;
      end
      check("report_within_budget", (n_reports >= target) ? 1 : 0, 1);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] st;
      int         rep0;

      add_vec("z",   1'b1, 8'h1D, 8'h00);
      add_vec("M",   1'b1, 8'h10, 8'h02);
      add_vec("9",   1'b1, 8'h26, 8'h00);
      add_vec(8'h0D, 1'b1, 8'h28, 8'h00);
      add_vec(8'h1B, 1'b1, 8'h29, 8'h00);
      add_vec(8'h08, 1'b1, 8'h2A, 8'h00);
      add_vec(8'h09, 1'b1, 8'h2B, 8'h00);
      add_vec(8'h20, 1'b1, 8'h2C, 8'h00);
      add_vec(8'h2D, 1'b1, 8'h2D, 8'h00);
      add_vec(8'h3D, 1'b1, 8'h2E, 8'h00);
      add_vec(8'h5C, 1'b1, 8'h31, 8'h00);
      add_vec(8'h3B, 1'b1, 8'h33, 8'h00);
      add_vec(8'h60, 1'b1, 8'h35, 8'h00);
      add_vec(8'h2C, 1'b1, 8'h36, 8'h00);
      add_vec(8'h2F, 1'b1, 8'h38, 8'h00);
      add_vec(8'h40, 1'b1, 8'h1F, 8'h02);
      add_vec(8'h5E, 1'b1, 8'h23, 8'h02);
      add_vec(8'h29, 1'b1, 8'h27, 8'h02);
      add_vec(8'h5F, 1'b1, 8'h2D, 8'h02);
      add_vec(8'h7C, 1'b1, 8'h31, 8'h02);
      add_vec(8'h3A, 1'b1, 8'h33, 8'h02);
      add_vec(8'h22, 1'b1, 8'h34, 8'h02);
      add_vec(8'h7E, 1'b1, 8'h35, 8'h02);
      add_vec(8'h3E, 1'b1, 8'h37, 8'h02);
      add_vec(8'h3F, 1'b1, 8'h38, 8'h02);
      add_vec(8'h7F, 1'b0, 8'h00, 8'h00);
      add_vec(8'hFF, 1'b0, 8'h00, 8'h00);
      add_vec(8'h00, 1'b0, 8'h00, 8'h00);
      add_vec(8'h1C, 1'b0, 8'h00, 8'h00);
`ifdef KBD_ENC_CTRL_EN
      add_vec(8'h03, 1'b1, 8'h06, 8'h01);
      add_vec(8'h01, 1'b1, 8'h04, 8'h01);
      add_vec(8'h1A, 1'b1, 8'h1D, 8'h01);
`else
      add_vec(8'h03, 1'b0, 8'h00, 8'h00);
      add_vec(8'h01, 1'b0, 8'h00, 8'h00);
      add_vec(8'h1A, 1'b0, 8'h00, 8'h00);
`endif

      $display("[TB] reset checks");
      #1;
      check("reset_typ", typ, 0);
      check("reset_report", report, 0);
      check("reset_key1", key1, 0);
      check("reset_mods", key_modifiers, 0);
      check("reset_key2", key2, 0);
      repeat (3) @(negedge clk_i);
      rst_n_i = 1'b1;
      @(negedge clk_i);
      check("typ_after_reset", typ, 1);
      cpu_read(8'h00, st);
      check("reset_status", st, 8'h02);
      cpu_read(8'h01, st);
      check("reset_ticks", st, 8);
      cpu_read(8'h05, st);
      check("unused_addr_read", st, 0);

      cpu_write(8'h01, 8'h01);

      $display("[TB] single character timing");
      push_expected(1'b1, 8'h04, 8'h00);
      cpu_write(8'h00, "a");
      rep0 = last_wr_cycle;
      wait_idle(200);
      check("press_latency", press_cycle - rep0, 2);
      check("release_after_press", rel_cycle - press_cycle, TICK_DIV + 1);
      check("queue_drained_a", exp_q.size(), 0);

      $display("[TB] table vectors");
      for (int i = 0; i < vecs.size(); i++) begin
         push_expected(vecs[i].valid, vecs[i].key, vecs[i].mods);
         cpu_write(8'h00, vecs[i].ch);
         wait_idle(200);
         cpu_read(8'h00, st);
         check($sformatf("unmapped_flag_%02h", vecs[i].ch), st[4], vecs[i].valid ? 0 : 1);
         check($sformatf("queue_drained_%02h", vecs[i].ch), exp_q.size(), 0);
         if (st[4]) cpu_write(8'h02, 8'h00);
      end

      $display("[TB] back-to-back characters");
      push_expected(1'b1, 8'h04, 8'h02);
      push_expected(1'b1, 8'h1E, 8'h02);
      push_expected(1'b1, 8'h27, 8'h00);
      rep0 = n_reports;
      cpu_write(8'h00, "A");
      cpu_write(8'h00, 8'h21);
      cpu_write(8'h00, "0");
      wait_idle(500);
      check("busy_until_all_reports", n_reports - rep0, 6);
      check("busy_fall_after_gap", cycle - rel_cycle, TICK_DIV + 1);
      check("queue_drained_b2b", exp_q.size(), 0);

      $display("[TB] unmapped then mapped");
      push_expected(1'b1, 8'h05, 8'h00);
      cpu_write(8'h00, 8'h80);
      cpu_write(8'h00, "b");
      wait_idle(200);
      cpu_read(8'h00, st);
      check("unmapped_set", st[4], 1);
      check("queue_drained_b", exp_q.size(), 0);
      cpu_write(8'h02, 8'h5A);
      cpu_read(8'h00, st);
      check("unmapped_cleared", st[4], 0);

      $display("[TB] overflow while stalled in HOLD");
      cpu_write(8'h01, 8'd50);
      push_expected(1'b1, 8'h06, 8'h00);
      rep0 = n_reports;
      cpu_write(8'h00, "c");
      wait_reports(rep0 + 1, 20);
      for (int i = 0; i < 17; i++) begin
         if (i < 16) push_expected(1'b1, 8'h07 + 8'(i), 8'h00);
         cpu_write(8'h00, 8'h64 + 8'(i));
      end
      cpu_read(8'h00, st);
      check("overflow_set", st[3], 1);
      check("full_set", st[2], 1);
      check("busy_in_hold", st[0], 1);
      cpu_write(8'h01, 8'h01);
      wait_idle(3000);
      check("queue_drained_overflow", exp_q.size(), 0);
      cpu_read(8'h00, st);
      check("overflow_sticky", st[3], 1);
      cpu_write(8'h02, 8'h00);
      cpu_read(8'h00, st);
      check("overflow_cleared", st, 8'h02);

      $display("[TB] reset during HOLD");
      cpu_write(8'h01, 8'd50);
      push_expected(1'b1, 8'h08, 8'h00);
      push_expected(1'b1, 8'h09, 8'h00);
      rep0 = n_reports;
      cpu_write(8'h00, "e");
      cpu_write(8'h00, "f");
      wait_reports(rep0 + 1, 20);
      repeat (10) @(negedge clk_i);
      rst_n_i = 1'b0;
      #1;
      check("midreset_report", report, 0);
      check("midreset_key1", key1, 0);
      check("midreset_mods", key_modifiers, 0);
      check("midreset_typ", typ, 0);
      exp_q.delete();
      @(negedge clk_i);
      rst_n_i = 1'b1;
      @(negedge clk_i);
      cpu_read(8'h00, st);
      check("status_after_midreset", st, 8'h02);
      rep0 = n_reports;
      repeat (300) @(negedge clk_i);
      check("no_reports_after_midreset", n_reports - rep0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
